// File: rtl/cam_cfg_pkg.sv
// Shared types and table markers for the camera configuration sequencer.
// The ROM generator imports the marker values from here as well.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_SEND, ST_WAIT, ST_DELAY, ST_NEXT, ST_DONE
  } cfg_state_e;

  localparam logic [15:0] CFG_DELAY_MARK = 16'hFFF0;
  localparam logic [15:0] CFG_END_MARK   = 16'hFFFF;

  function automatic int delay_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/cam_cfg_delay.sv
// Loadable down-counter with a zero flag; stops at zero.
// Also used by the capture logic, so it carries no sequencer knowledge.
module cam_cfg_delay #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt <= '0;
    else if (load)                 cnt <= load_val;
    else if (dec && cnt != '0)     cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks the camera config ROM, issuing each {reg,value} entry as one SCCB
// write, honouring delay markers and retrying NACKed writes.
module cam_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int          CLK_FREQ_HZ = 25_000_000,
  parameter int          DELAY_MS    = 1,
  parameter int          ROM_AW      = 7,
  parameter logic [15:0] DELAY_MARK  = CFG_DELAY_MARK,
  parameter logic [15:0] END_MARK    = CFG_END_MARK,
  parameter int          MAX_RETRY   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [7:0]        o_wr_reg,
  output logic [7:0]        o_wr_data,
  input  logic              i_wr_done,
  input  logic              i_wr_nack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int DLY_CYC = delay_cycles(CLK_FREQ_HZ, DELAY_MS);
  localparam int DW      = (DLY_CYC > 1) ? $clog2(DLY_CYC) : 1;
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [DW-1:0] DLY_LOAD = DW'(DLY_CYC - 1);

  cfg_state_e    state;
  logic [RW-1:0] retry;
  logic          dly_zero;
  logic          dly_load;
  logic          dly_dec;

  assign dly_load = (state == ST_DECODE) && (i_rom_data == DELAY_MARK);
  assign dly_dec  = (state == ST_DELAY);

  cam_cfg_delay #(.W(DW)) u_delay (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (dly_load),
    .load_val (DLY_LOAD),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      o_rom_addr <= '0;
      o_wr_valid <= 1'b0;
      o_wr_reg   <= '0;
      o_wr_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      retry      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state      <= ST_FETCH;
            o_rom_addr <= '0;
            o_busy     <= 1'b1;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            retry      <= '0;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          if (i_rom_data == END_MARK) begin
            state  <= ST_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else if (i_rom_data == DELAY_MARK) begin
            state <= ST_DELAY;
          end else begin
            o_wr_reg   <= i_rom_data[15:8];
            o_wr_data  <= i_rom_data[7:0];
            o_wr_valid <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_wr_ready) begin
            o_wr_valid <= 1'b0;
            state      <= ST_WAIT;
          end
        end
        // NACK wins over a coincident done.
        ST_WAIT: begin
          if (i_wr_nack) begin
            if (retry < RW'(MAX_RETRY)) begin
              retry      <= retry + RW'(1);
              o_wr_valid <= 1'b1;
              state      <= ST_SEND;
            end else begin
              retry  <= '0;
              o_err  <= 1'b1;
              o_busy <= 1'b0;
              o_done <= 1'b1;
              state  <= ST_DONE;
            end
          end else if (i_wr_done) begin
            retry <= '0;
            state <= ST_NEXT;
          end
        end
        ST_DELAY: if (dly_zero) state <= ST_NEXT;
        ST_NEXT: begin
          if (o_rom_addr == {ROM_AW{1'b1}}) begin
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= ST_DONE;
          end else begin
            o_rom_addr <= o_rom_addr + ROM_AW'(1);
            state      <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer: ROM and SCCB slave models, a table of directed
// passes, corner-case sequences and randomized passes against a table-walk model.
module tb_cam_cfg_sequencer;
  import cam_cfg_pkg::*;

  localparam int AW   = 7;
  localparam int MR   = 2;
  localparam int DCYC = 1000;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          wr_valid, wr_ready = 1'b1;
  logic [7:0]    wr_reg, wr_data;
  logic          slv_done = 1'b0, slv_nack = 1'b0, inj_done = 1'b0;
  logic          wr_done, wr_nack;
  logic          busy, done, err;

  assign wr_done = slv_done | inj_done;
  assign wr_nack = slv_nack;

  always #5 clk = ~clk;

  cam_cfg_sequencer #(
    .CLK_FREQ_HZ(1_000_000), .DELAY_MS(1), .ROM_AW(AW),
    .DELAY_MARK(16'hFFF0), .END_MARK(16'hFFFF), .MAX_RETRY(MR)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_wr_valid(wr_valid), .i_wr_ready(wr_ready),
    .o_wr_reg(wr_reg), .o_wr_data(wr_data),
    .i_wr_done(wr_done), .i_wr_nack(wr_nack),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  logic [15:0] rom [2**AW];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, stall_left = 0, nack_left = 0, stall_ok = 0, pcnt = 0, prev_addr = -1;
  logic        pend = 1'b0;
  logic [15:0] stall_exp = 16'h1280;
  logic [15:0] xq[$];
  int          tq[$];
  int          aq[$];

  // SCCB slave + monitor: responds 5 cycles after each transfer.
  initial forever begin
    @(negedge clk);
    cyc++;
    slv_done = 1'b0;
    slv_nack = 1'b0;
    if (rst) begin
      pend     = 1'b0;
      wr_ready = 1'b1;
    end else begin
      if (pend) begin
        if (pcnt == 0) begin
          pend = 1'b0;
          if (nack_left > 0) begin slv_nack = 1'b1; nack_left--; end
          else slv_done = 1'b1;
        end else pcnt--;
      end
      if (wr_valid && stall_left > 0) begin
        wr_ready = 1'b0;
        stall_left--;
        if ({wr_reg, wr_data} == stall_exp) stall_ok++;
      end else wr_ready = 1'b1;
      if (wr_valid && wr_ready) begin
        xq.push_back({wr_reg, wr_data});
        tq.push_back(cyc);
        pend = 1'b1;
        pcnt = 4;
      end
      if (busy && int'(rom_addr) != prev_addr) begin
        aq.push_back(int'(rom_addr));
        prev_addr = int'(rom_addr);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp_v);
    end
  endtask

  // Reference: walk the table entry by entry, spending NACKs from a global budget.
  logic [15:0] m_q[$];
  int m_err, m_last;
  task automatic model(input int nb);
    int a;
    bit fin;
    m_q.delete();
    a = 0; fin = 0; m_err = 0; m_last = 0;
    while (!fin) begin
      if (rom[a] == 16'hFFFF) begin
        m_last = a; fin = 1;
      end else begin
        if (rom[a] != 16'hFFF0) begin
          bit ok = 0;
          for (int k = 0; k <= MR; k++) begin
            m_q.push_back(rom[a]);
            if (nb > 0) nb--;
            else begin ok = 1; break; end
          end
          if (!ok) begin m_err = 1; m_last = a; fin = 1; end
        end
        if (!fin) begin
          if (a == 2**AW - 1) begin m_err = 1; m_last = a; fin = 1; end
          else a++;
        end
      end
    end
  endtask

  task automatic load_rom(input int kind);
    for (int i = 0; i < 2**AW; i++) rom[i] = (kind == 2) ? 16'h0C00 : 16'hFFFF;
    if (kind == 0) begin
      rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
    end else if (kind == 1) begin
      rom[0] = 16'h3A04; rom[1] = 16'hFFFF;
    end
  endtask

  task automatic begin_pass(input int nb, input int st);
    nack_left = nb; stall_left = st; stall_ok = 0;
    xq.delete(); tq.delete(); aq.delete(); prev_addr = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_start", busy, 1);
    check("done_clr", done, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20000) begin @(negedge clk); n++; end
    check("pass_timeout", done, 1);
    if (!done) begin
      rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    end
  endtask

  task automatic wait_xfers(input int n);
    int k = 0;
    while (xq.size() < n && k < 5000) begin @(negedge clk); k++; end
    check("wait_xfer", int'(xq.size() >= n), 1);
  endtask

  task automatic check_pass(input int nb, input int ex_x, input int ex_e, input int ex_l,
                            input int st, input bit gap);
    int bad = 0;
    model(nb);
    check("busy_end", busy, 0);
    check("valid_end", wr_valid, 0);
    check("err", err, m_err);
    check("last_addr", rom_addr, m_last);
    check("xfer_cnt", xq.size(), m_q.size());
    for (int i = 0; i < xq.size() && i < m_q.size(); i++) check("xfer", xq[i], m_q[i]);
    for (int i = 0; i < aq.size(); i++) if (aq[i] != i) bad++;
    check("addr_cnt", aq.size(), m_last + 1);
    check("addr_order", bad, 0);
    if (ex_x >= 0) begin
      check("tbl_xfers", xq.size(), ex_x);
      check("tbl_err", err, ex_e);
      check("tbl_last", rom_addr, ex_l);
    end
    if (st > 0) check("stall_hold", stall_ok, st);
    if (gap) check("delay_gap", int'(tq.size() >= 2 && tq[1] - tq[0] >= DCYC), 1);
  endtask

  task automatic check_reset_vals();
    check("rst_addr", rom_addr, 0);
    check("rst_valid", wr_valid, 0);
    check("rst_reg", wr_reg, 0);
    check("rst_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
  endtask

  typedef struct {
    int kind; int nack; int stall; int xfers; int err; int last; bit gap;
  } vec_t;
  vec_t vecs[5];

  initial begin
    vecs[0] = '{0, 0,  0,   2, 0,   3, 1};  // basic table with a delay
    vecs[1] = '{0, 0,  20,  2, 0,   3, 1};  // backpressure on first write
    vecs[2] = '{1, 99, 0,   3, 1,   0, 0};  // persistent NACK
    vecs[3] = '{1, 1,  0,   2, 0,   1, 0};  // single NACK then ACK
    vecs[4] = '{2, 0,  0, 128, 1, 127, 0};  // no end marker

    load_rom(0);
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      load_rom(vecs[v].kind);
      begin_pass(vecs[v].nack, vecs[v].stall);
      wait_done();
      check_pass(vecs[v].nack, vecs[v].xfers, vecs[v].err, vecs[v].last,
                 vecs[v].stall, vecs[v].gap);
    end

    // Reset in the middle of the delay, then a clean pass.
    load_rom(0);
    begin_pass(0, 0);
    wait_xfers(1);
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    begin_pass(0, 0);
    wait_done();
    check_pass(0, 2, 0, 3, 0, 1);

    // Stray done in DELAY and a start during the second write are both ignored.
    load_rom(0);
    begin_pass(0, 0);
    wait_xfers(1);
    repeat (300) @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    wait_xfers(2);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_ignored", busy, 1);
    wait_done();
    check_pass(0, 2, 0, 3, 0, 1);

    // Randomized tables against the model.
    for (int r = 0; r < 8; r++) begin
      int len, nb, st;
      bit used_dly;
      len = $urandom_range(1, 12);
      nb  = $urandom_range(0, 4);
      st  = $urandom_range(0, 3);
      used_dly = 0;
      for (int i = 0; i < 2**AW; i++) rom[i] = 16'hFFFF;
      for (int i = 0; i < len; i++) begin
        logic [15:0] e;
        e = 16'($urandom);
        if (e >= 16'hFFF0) e = 16'h0C00 | 16'(i);
        if (!used_dly && $urandom_range(0, 7) == 0) begin e = 16'hFFF0; used_dly = 1; end
        rom[i] = e;
      end
      stall_exp = (rom[0] == 16'hFFF0) ? rom[1] : rom[0];
      begin_pass(nb, 0);
      wait_done();
      check_pass(nb, -1, 0, 0, 0, 0);
      stall_left = st;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
